div_seq: RTL and testbench

Multi-cycle integer divide sequencer for the pipelined MIPS core. It accepts a DIV/DIVU request from the execute stage and runs a 32-iteration restoring division. While it runs, it stalls the pipeline through the hazard path. It then delivers quotient/remainder for the HI/LO write (LO = quotient, HI = remainder).

---
 rtl/mips_pkg.sv | 17 +
 rtl/div_seq_if.sv | 33 +++
 rtl/div_step.sv | 27 ++
 rtl/div_seq.sv | 130 +++++++++++++
 tb/tb_div_seq.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the multi-cycle divide sequencer
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_CYCLES = 32;
    localparam int DIV_CNT_W  = 5;

    function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
        return (isSigned && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - E-stage <-> divider request/result bundle; dbz only with DIV_DBZ_FAST_EN
interface div_seq_if #(parameter int DIV_W = 32);

    logic             start;
    logic             signed_div;
    logic             annul;
    logic [DIV_W-1:0] a;
    logic [DIV_W-1:0] b;
    logic             stall;
    logic             ready;
    logic [DIV_W-1:0] hi;
    logic [DIV_W-1:0] lo;
`ifdef DIV_DBZ_FAST_EN
    logic             dbz;
`endif

    modport master (
        output start, signed_div, annul, a, b,
`ifdef DIV_DBZ_FAST_EN
        input  dbz,
`endif
        input  stall, ready, hi, lo
    );

    modport slave (
        input  start, signed_div, annul, a, b,
`ifdef DIV_DBZ_FAST_EN
        output dbz,
`endif
        output stall, ready, hi, lo
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   remIn,
    input  logic [W-1:0] quoIn,
    input  logic [W-1:0] divisor,
    output logic [W:0]   remOut,
    output logic [W-1:0] quoOut
);

    logic [W+1:0] shifted;
    logic [W+1:0] trial;

    always_comb begin
        shifted = {remIn, quoIn[W-1]};
        trial   = shifted - {2'b00, divisor};
        if (!trial[W+1]) begin
            remOut = trial[W:0];
            quoOut = {quoIn[W-2:0], 1'b1};
        end else begin
            remOut = shifted[W:0];
            quoOut = {quoIn[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - 32-iteration restoring DIV/DIVU sequencer with pipeline stall and HI/LO result
// Optional macro DIV_DBZ_FAST_EN: zero divisor finishes in one cycle and drives dbz.
module div_seq
    import mips_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);

    div_state_t           state, nextState;
    logic [DIV_CNT_W-1:0] count;
    logic [DIV_W:0]       rem;
    logic [DIV_W-1:0]     quo;
    logic [DIV_W-1:0]     divisor;
    logic [DIV_W-1:0]     aOrig;
    logic [DIV_W-1:0]     hiR, loR;
    logic                 negQ, negR, divZero;
    logic                 accept, lastStep;
    logic [DIV_W:0]       stepRem;
    logic [DIV_W-1:0]     stepQuo;

    div_step #(.W(DIV_W)) u_step (
        .remIn   (rem),
        .quoIn   (quo),
        .divisor (divisor),
        .remOut  (stepRem),
        .quoOut  (stepQuo)
    );

    assign accept   = (state == IDLE) && bus.start && !bus.annul;
    assign lastStep = (count == DIV_CNT_W'(DIV_CYCLES - 1));

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DIV_DBZ_FAST_EN
                    nextState = (bus.b == '0) ? DONE : BUSY;
`else
                    nextState = BUSY;
`endif
                end
            end
            BUSY: begin
                if (bus.annul)
                    nextState = IDLE;
                else if (lastStep)
                    nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Gate with rst so a reset landing mid-BUSY drops the hold immediately.
    assign bus.stall = !rst && (accept || (state == BUSY));
    assign bus.ready = (state == DONE);
    assign bus.hi    = hiR;
    assign bus.lo    = loR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            aOrig   <= '0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
            hiR     <= '0;
            loR     <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (accept) begin
                        quo     <= absVal(bus.a, bus.signed_div);
                        divisor <= absVal(bus.b, bus.signed_div);
                        aOrig   <= bus.a;
                        rem     <= '0;
                        count   <= '0;
                        negQ    <= bus.signed_div && (bus.a[DIV_W-1] ^ bus.b[DIV_W-1]);
                        negR    <= bus.signed_div && bus.a[DIV_W-1];
                        divZero <= (bus.b == '0);
`ifdef DIV_DBZ_FAST_EN
                        if (bus.b == '0) begin
                            loR <= '1;
                            hiR <= bus.a;
                        end
`endif
                    end
                end
                BUSY: begin
                    if (!bus.annul) begin
                        rem   <= stepRem;
                        quo   <= stepQuo;
                        count <= count + 1'b1;
                        // Zero divisor result is forced; the iterations are discarded.
                        if (lastStep) begin
                            loR <= divZero ? '1 : (negQ ? -stepQuo : stepQuo);
                            hiR <= divZero ? aOrig
                                           : (negR ? -stepRem[DIV_W-1:0] : stepRem[DIV_W-1:0]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_DBZ_FAST_EN
    logic dbzR;

    always_ff @(posedge clk) begin
        if (rst)
            dbzR <= 1'b0;
        else
            dbzR <= (state == IDLE) && (nextState == DONE);
    end

    assign bus.dbz = dbzR;
`endif

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed self-checking bench for div_seq (honours DIV_DBZ_FAST_EN)
module tb_div_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    div_seq_if #(.DIV_W(32)) bus ();

    div_seq #(.DIV_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int nCompared   = 0;
    int nMismatched = 0;

`ifdef DIV_DBZ_FAST_EN
    localparam int DBZ_CYC = 1;
`else
    localparam int DBZ_CYC = 33;
`endif

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the cycle start is driven in; outputs are sampled at each negedge.
    task automatic runDiv(input logic [31:0] va, input logic [31:0] vb, input logic sgn,
                          input logic [31:0] expLo, input logic [31:0] expHi,
                          input int expCyc, input bit noWait, input string tag);
        int readyCyc = -1;
        int readyCnt = 0;
        int stallErr = 0;
        int dbzErr   = 0;
        if (!noWait) @(negedge clk);
        bus.a = va; bus.b = vb; bus.signed_div = sgn; bus.annul = 1'b0; bus.start = 1'b1;
        #1;
        checkEq({tag, "_stall_c0"}, 32'(bus.stall), 32'd1);
        for (int c = 1; c <= expCyc + 1; c++) begin
            @(negedge clk);
            if (bus.ready) begin
                readyCnt++;
                if (readyCyc < 0) readyCyc = c;
            end
            if (bus.stall !== (c < expCyc)) stallErr++;
`ifdef DIV_DBZ_FAST_EN
            if (bus.dbz !== ((c == expCyc) && (vb == 32'd0))) dbzErr++;
`endif
            if (c == expCyc) begin
                checkEq({tag, "_lo"}, bus.lo, expLo);
                checkEq({tag, "_hi"}, bus.hi, expHi);
            end
            bus.start = 1'b0;
        end
        checkEq({tag, "_ready_cycle"}, 32'(readyCyc), 32'(expCyc));
        checkEq({tag, "_ready_count"}, 32'(readyCnt), 32'd1);
        checkEq({tag, "_stall_profile_errs"}, 32'(stallErr), 32'd0);
        checkEq({tag, "_dbz_errs"}, 32'(dbzErr), 32'd0);
    endtask

    initial begin
        int readyCnt;
        int r1;
        int r2;

        bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
        bus.a = '0; bus.b = '0;

        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd3;
        #1;
        checkEq("rst_stall", 32'(bus.stall), 32'd0);
        checkEq("rst_ready", 32'(bus.ready), 32'd0);
        checkEq("rst_hi", bus.hi, 32'd0);
        checkEq("rst_lo", bus.lo, 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;

        runDiv(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b0, "divu_100_7");

        // annul in cycle 10: back to IDLE in cycle 11, result untouched
        @(negedge clk);
        bus.a = 32'd50; bus.b = 32'd5; bus.signed_div = 1'b0; bus.start = 1'b1;
        readyCnt = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (bus.ready) readyCnt++;
            bus.start = 1'b0;
            if (c == 10) bus.annul = 1'b1;
            if (c == 11) begin
                checkEq("annul_stall_c11", 32'(bus.stall), 32'd0);
                checkEq("annul_hi", bus.hi, 32'd2);
                checkEq("annul_lo", bus.lo, 32'd14);
                bus.annul = 1'b0;
            end
        end
        checkEq("annul_no_ready", 32'(readyCnt), 32'd0);
        runDiv(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 33, 1'b1, "after_annul_50_5");

        runDiv(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0, "div_m7_2");
        runDiv(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33, 1'b0, "div_7_m2");
        runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, 1'b0, "div_ovf");
        runDiv(32'hFFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FFFF, 32'd15, 33, 1'b0, "divu_max_16");
        runDiv(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, DBZ_CYC, 1'b0, "divu_5_0");
        runDiv(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, DBZ_CYC, 1'b0, "div_m5_0");

        // start together with annul in IDLE is dropped
        @(negedge clk);
        bus.a = 32'd8; bus.b = 32'd2; bus.start = 1'b1; bus.annul = 1'b1;
        #1;
        checkEq("start_annul_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.annul = 1'b0;
        #1;
        checkEq("start_annul_idle_stall", 32'(bus.stall), 32'd0);
        checkEq("start_annul_ready", 32'(bus.ready), 32'd0);

        // reset asserted in cycle 15 of a divide
        @(negedge clk);
        bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 15) rst = 1'b1;
            if (c == 16) begin
                checkEq("midrst_stall", 32'(bus.stall), 32'd0);
                checkEq("midrst_ready", 32'(bus.ready), 32'd0);
                checkEq("midrst_hi", bus.hi, 32'd0);
                checkEq("midrst_lo", bus.lo, 32'd0);
                rst = 1'b0;
            end
        end
        @(negedge clk);
        checkEq("postrst_stall", 32'(bus.stall), 32'd0);

        // back-to-back with start held high
        @(negedge clk);
        bus.a = 32'd9; bus.b = 32'd3; bus.signed_div = 1'b0; bus.start = 1'b1;
        readyCnt = 0; r1 = -1; r2 = -1;
        for (int c = 1; c <= 69; c++) begin
            @(negedge clk);
            if (bus.ready) begin
                readyCnt++;
                if (r1 < 0) begin
                    r1 = c;
                    checkEq("b2b_first_lo", bus.lo, 32'd3);
                    checkEq("b2b_first_hi", bus.hi, 32'd0);
                end else begin
                    r2 = c;
                    checkEq("b2b_second_lo", bus.lo, 32'd2);
                    checkEq("b2b_second_hi", bus.hi, 32'd2);
                end
            end
            if (c == 34) checkEq("b2b_stall_c34", 32'(bus.stall), 32'd1);
            if (c == 33) begin
                bus.a = 32'd10; bus.b = 32'd4;
            end
            if (c == 67) bus.start = 1'b0;
        end
        checkEq("b2b_ready1_cycle", 32'(r1), 32'd33);
        checkEq("b2b_ready2_cycle", 32'(r2), 32'd67);
        checkEq("b2b_ready_count", 32'(readyCnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
